ccff_loader: RTL
================

CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 16: number of configuration flip-flops in the downstream ccff chain; legal range 1..65535.
REQ-002 Parameter SENTINEL, default 8'hA5: marker shifted ahead of the bitstream and checked on return.
REQ-003 prog_clk  in  1  sole clock, rising-edge.
REQ-004 pReset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
REQ-006 abort  in  1  terminate any load in progress.
REQ-007 s_data  in  8  bitstream byte, shifted LSB first.
REQ-008 s_valid  in  1  s_data valid.
REQ-009 s_ready  out  1  byte accepted when s_valid and s_ready are both high on a clock edge.
REQ-010 ccff_head  out  1  serial data to the chain head.
REQ-011 ccff_tail  in  1  serial data returned from the chain tail.
REQ-012 chain_clk_en  out  1  enable for the external prog_clk gate; the chain shifts one position on each edge where this is high.
REQ-013 config_enable  out  1  high in SENT and DATA only.
REQ-014 IO_ISOL_N  out  1  I/O isolation release; low = isolated.
REQ-015 busy, done, pass  out  1 each  status flags.

Function
REQ-016 States: IDLE, SENT, DATA, DONE.
REQ-017 Transitions:
- IDLE/DONE->SENT on start.
- SENT->DATA after 8 shifts.
- DATA->DONE after CHAIN_LEN+8 total shifts.
- Any state->IDLE on abort; abort has priority over start.
REQ-018 Shift index n counts chain_clk_en edges from 0 within one load.
REQ-019 Shifts 0..7 present SENTINEL[n] on ccff_head, chain_clk_en=1 every cycle in SENT, no stream data needed.
REQ-020 Shifts 8..CHAIN_LEN+7 present stream bits in arrival order, LSB first.
REQ-021 A DATA-state shift occurs only when a buffered bit is available; otherwise chain_clk_en=0 and ccff_head holds its value (stall).
REQ-022 s_ready is high in DATA when data bits remain and the byte buffer is empty or its last bit is shifted this cycle; sustained throughput is one bit per cycle with no byte bubble.
REQ-023 Once CHAIN_LEN data bits are consumed, s_ready=0 and unused bits of the final byte are discarded.
REQ-024 On each shift edge n with CHAIN_LEN <= n <= CHAIN_LEN+7, ccff_tail is sampled and compared to SENTINEL[n-CHAIN_LEN]; any mismatch sets a sticky error flag cleared at start.
REQ-025 On DONE entry: done=1, pass=!error, both held until the next start or abort.
REQ-026 IO_ISOL_N=1 only in DONE with pass=1; it drops to 0 in the same cycle SENT is entered.
REQ-027 busy=1 in SENT and DATA.
REQ-028 start while busy is ignored.
REQ-029 Abort mid-load returns to IDLE; done=0, pass=0, IO_ISOL_N=0, buffer flushed, and chain contents are undefined.

Reset
REQ-030 While pReset_n=0, in IDLE:
- Forced low: s_ready, ccff_head, chain_clk_en, config_enable, IO_ISOL_N, busy, done, pass.
- Cleared: counters, byte buffer, error flag.
REQ-031 Reset release takes effect on the first prog_clk edge after pReset_n rises; no other sequencing is needed.

Structure
REQ-032 Shared package ccff_loader_pkg holds the state enum, the default SENTINEL constant, and the shift-counter width function clog2(CHAIN_LEN+9).
REQ-033 One sub-module, ccff_serializer: 8-bit byte buffer, bit count, s_ready generation, bit-valid/bit-take handshake to the FSM.
REQ-034 The single top-level FSM owns the counters, compare logic and outputs.

Verification
Bench: CHAIN_LEN=16, behavioural 16-bit shift-register chain clocked by prog_clk with chain_clk_en, tail = last stage.
REQ-035 start, bytes 8'h3C, 8'hF0 streamed back-to-back -> 24 shifts in 24 consecutive cycles; chain holds 16'hF03C (bit0 first in); done=1, pass=1, IO_ISOL_N=1.
REQ-036 As REQ-035, with s_valid low for 5 cycles between bytes -> chain_clk_en low exactly those 5 cycles; same final contents, pass=1.
REQ-037 Chain model tail stuck at 0 -> done=1, pass=0, IO_ISOL_N=0.
REQ-038 CHAIN_LEN=12, bytes 8'hFF, 8'h0F, 8'hAA offered -> only 2 bytes accepted, s_ready stays low; chain=12'hFFF, pass=1.
REQ-039 abort asserted at shift 10 -> next cycle IDLE, config_enable=0, chain_clk_en=0, done=0, IO_ISOL_N=0; a new start then loads correctly with pass=1.
REQ-040 pReset_n pulsed low during DATA -> all outputs 0 immediately, asynchronously; start accepted on the first edge after release.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// ---------------------------------------------------------------------------
// ccff_loader_pkg
// Shared definitions for the configuration-chain loader:
//   - FSM state encodings (IDLE, SENT, DATA, DONE)
//   - default sentinel marker shifted ahead of the bitstream
//   - clog2 helper used to size the shift counter
// ---------------------------------------------------------------------------
package ccff_loader_pkg;

    typedef logic [1:0] ccffState_t;

    localparam ccffState_t ST_IDLE = 2'd0;
    localparam ccffState_t ST_SENT = 2'd1;
    localparam ccffState_t ST_DATA = 2'd2;
    localparam ccffState_t ST_DONE = 2'd3;

    localparam logic [7:0] DEFAULT_SENTINEL = 8'hA5;

    // Width needed to count up to (value - 1); callers pass CHAIN_LEN+9 so
    // the counter can hold every shift index plus the terminal value.
    function automatic int clog2(input int value);
        return $clog2(value);
    endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_loader_if
// Byte-stream handshake feeding the loader.
//   s_data  : bitstream byte, consumed LSB first
//   s_valid : s_data is valid
//   s_ready : loader accepts the byte on an edge where s_valid is also high
// master = stream source, slave = loader.
// ---------------------------------------------------------------------------
interface ccff_loader_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/ccff_loader_serializer.sv
// ---------------------------------------------------------------------------
// ccff_serializer
// One-byte buffer that turns the byte stream into a bit stream for the FSM.
// Ports:
//   prog_clk, pReset_n : clock, async active-low reset
//   flush_i            : drop any buffered bits
//   accept_en_i        : FSM still wants more stream bits
//   s_bus              : byte-stream handshake (slave side)
//   bit_valid_o        : a buffered bit is available
//   bit_data_o         : the next bit (LSB of the buffer)
//   bit_take_i         : FSM consumes bit_data_o this cycle
//   bit_cnt_o          : number of bits still held in the buffer
// ---------------------------------------------------------------------------
module ccff_serializer (
    input  logic       prog_clk,
    input  logic       pReset_n,
    input  logic       flush_i,
    input  logic       accept_en_i,
    ccff_loader_if.slave s_bus,
    output logic       bit_valid_o,
    output logic       bit_data_o,
    input  logic       bit_take_i,
    output logic [3:0] bit_cnt_o
);

    logic [7:0] byteBuf_q, byteBuf_d;
    logic [3:0] bitCnt_q,  bitCnt_d;
    logic       byteLoad;

    // Accept a new byte when empty, or when the last buffered bit leaves this
    // cycle, so consecutive bytes stream with no bubble.
    assign s_bus.s_ready = accept_en_i &&
                           ((bitCnt_q == 4'd0) || ((bitCnt_q == 4'd1) && bit_take_i));
    assign byteLoad      = s_bus.s_valid && s_bus.s_ready;

    assign bit_valid_o = (bitCnt_q != 4'd0);
    assign bit_data_o  = byteBuf_q[0];
    assign bit_cnt_o   = bitCnt_q;

    // Flush wins over a load; a load overwrites the buffer even when the last
    // old bit is being taken in the same cycle.
    always_comb begin
        byteBuf_d = byteBuf_q;
        bitCnt_d  = bitCnt_q;
        if (flush_i) begin
            byteBuf_d = '0;
            bitCnt_d  = '0;
        end else if (byteLoad) begin
            byteBuf_d = s_bus.s_data;
            bitCnt_d  = 4'd8;
        end else if (bit_take_i && (bitCnt_q != 4'd0)) begin
            byteBuf_d = {1'b0, byteBuf_q[7:1]};
            bitCnt_d  = bitCnt_q - 4'd1;
        end
    end

    // Buffer registers.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            byteBuf_q <= '0;
            bitCnt_q  <= '0;
        end else begin
            byteBuf_q <= byteBuf_d;
            bitCnt_q  <= bitCnt_d;
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// ---------------------------------------------------------------------------
// ccff_loader
// Loads a serial configuration chain: shifts an 8-bit sentinel, then
// CHAIN_LEN stream bits, and checks the sentinel returning on ccff_tail.
// Ports:
//   prog_clk, pReset_n : clock, async active-low reset
//   start, abort       : begin a load / cancel (abort has priority)
//   s_bus              : byte-stream handshake (slave side)
//   ccff_head          : serial data into the chain
//   ccff_tail          : serial data returned from the chain
//   chain_clk_en       : chain shifts on each edge where this is high
//   config_enable      : high while loading (SENT, DATA)
//   IO_ISOL_N          : releases I/O isolation after a passing load
//   busy, done, pass   : status
// ---------------------------------------------------------------------------
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int         CHAIN_LEN = 16,
    parameter logic [7:0] SENTINEL  = DEFAULT_SENTINEL
) (
    input  logic prog_clk,
    input  logic pReset_n,
    input  logic start,
    input  logic abort,
    ccff_loader_if.slave s_bus,
    output logic ccff_head,
    input  logic ccff_tail,
    output logic chain_clk_en,
    output logic config_enable,
    output logic IO_ISOL_N,
    output logic busy,
    output logic done,
    output logic pass
);

    localparam int            CW          = clog2(CHAIN_LEN + 9);
    localparam logic [CW-1:0] SENT_LEN_W  = CW'(8);
    localparam logic [CW-1:0] LAST_SENT_W = CW'(7);
    localparam logic [CW-1:0] CHAIN_LEN_W = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] LAST_SHIFT_W = CW'(CHAIN_LEN + 7);

    ccffState_t    state_q, state_d;
    logic [CW-1:0] shiftCnt_q, shiftCnt_d;
    logic          errorFlag_q, errorFlag_d;
    logic          headHold_q, headHold_d;

    logic          shiftEn, headOut, serFlush, needData;
    logic          serBitValid, serBitData;
    logic [3:0]    serBitCnt;
    logic [CW-1:0] dataUsed;
    logic [2:0]    cmpIdx;
    logic          tailMismatch;

    ccff_serializer u_serializer (
        .prog_clk    (prog_clk),
        .pReset_n    (pReset_n),
        .flush_i     (serFlush),
        .accept_en_i (needData),
        .s_bus       (s_bus),
        .bit_valid_o (serBitValid),
        .bit_data_o  (serBitData),
        .bit_take_i  (shiftEn && (state_q == ST_DATA)),
        .bit_cnt_o   (serBitCnt)
    );

    // Stream bits still owed = CHAIN_LEN minus bits shifted minus bits already
    // buffered. The buffer is also allowed to prefetch during SENT so the first
    // data bit follows the last sentinel bit without a gap.
    assign dataUsed = (shiftCnt_q >= SENT_LEN_W) ? (shiftCnt_q - SENT_LEN_W) : '0;
    assign needData = busy && !abort && ((dataUsed + CW'(serBitCnt)) < CHAIN_LEN_W);

    // Shift enable and head value. A DATA stall keeps the previous head bit.
    always_comb begin
        shiftEn = 1'b0;
        headOut = 1'b0;
        case (state_q)
            ST_SENT: begin
                shiftEn = !abort;
                headOut = SENTINEL[shiftCnt_q[2:0]];
            end
            ST_DATA: begin
                shiftEn = serBitValid && !abort;
                headOut = shiftEn ? serBitData : headHold_q;
            end
            default: begin
            end
        endcase
    end

    // The sentinel re-emerges at the tail once CHAIN_LEN positions have shifted.
    assign cmpIdx       = 3'(shiftCnt_q - CHAIN_LEN_W);
    assign tailMismatch = shiftEn && (shiftCnt_q >= CHAIN_LEN_W) &&
                          (shiftCnt_q <= LAST_SHIFT_W) &&
                          (ccff_tail != SENTINEL[cmpIdx]);

    // Next-state logic: abort > start > shift progress.
    always_comb begin
        state_d     = state_q;
        shiftCnt_d  = shiftCnt_q;
        errorFlag_d = errorFlag_q;
        headHold_d  = shiftEn ? headOut : headHold_q;
        serFlush    = 1'b0;
        if (abort) begin
            state_d     = ST_IDLE;
            shiftCnt_d  = '0;
            errorFlag_d = 1'b0;
            serFlush    = 1'b1;
        end else if (start && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
            state_d     = ST_SENT;
            shiftCnt_d  = '0;
            errorFlag_d = 1'b0;
            serFlush    = 1'b1;
        end else if (shiftEn) begin
            shiftCnt_d = shiftCnt_q + CW'(1);
            if (tailMismatch) begin
                errorFlag_d = 1'b1;
            end
            if ((state_q == ST_SENT) && (shiftCnt_q == LAST_SENT_W)) begin
                state_d = ST_DATA;
            end else if ((state_q == ST_DATA) && (shiftCnt_q == LAST_SHIFT_W)) begin
                state_d  = ST_DONE;
                serFlush = 1'b1;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q     <= ST_IDLE;
            shiftCnt_q  <= '0;
            errorFlag_q <= 1'b0;
            headHold_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shiftCnt_q  <= shiftCnt_d;
            errorFlag_q <= errorFlag_d;
            headHold_q  <= headHold_d;
        end
    end

    // Outputs decode straight from the registered state so reset forces them
    // low asynchronously.
    assign busy          = (state_q == ST_SENT) || (state_q == ST_DATA);
    assign config_enable = busy;
    assign done          = (state_q == ST_DONE);
    assign pass          = done && !errorFlag_q;
    assign IO_ISOL_N     = pass;
    assign chain_clk_en  = shiftEn;
    assign ccff_head     = headOut;

endmodule
